// File: rtl/cpu_ahb_master.sv
// CPU-side AHB-Lite master: one CPU load/store becomes one arbitrated SINGLE transfer,
// with wait states, RETRY/SPLIT re-issue, grant timeout and request legality checks.
module cpu_ahb_master #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int GRANT_TIMEOUT = 255,
    parameter int RETRY_MAX     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic              cpu_ce_i,
    input  logic              cpu_we_i,
    input  logic [DATA_W-1:0] cpu_writedata_i,
    input  logic [2:0]        cpu_sel_i,
    output logic [DATA_W-1:0] cpu_readdata_o,
    output logic              cpu_err_o,
    output logic              stallreq,
    input  logic              M_HGRANT,
    input  logic              M_HREADY,
    input  logic [1:0]        M_HRESP,
    input  logic [DATA_W-1:0] M_HRDATA,
    output logic              M_HBUSREQ,
    output logic [ADDR_W-1:0] M_HADDR,
    output logic [1:0]        M_HTRANS,
    output logic [2:0]        M_HSIZE,
    output logic [2:0]        M_HBURST,
    output logic              M_HWRITE,
    output logic [DATA_W-1:0] M_HWDATA
);

    localparam int MAX_SIZE = $clog2(DATA_W / 8);
    localparam int TW = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'((GRANT_TIMEOUT > 0) ? GRANT_TIMEOUT - 1 : 0);
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
    localparam bit TMO_EN = (GRANT_TIMEOUT != 0);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [2:0]        lat_sel;
    logic [TW-1:0]     tmo_cnt;
    logic [RW-1:0]     retry_cnt;
    logic [DATA_W-1:0] rdata_q;

    logic [7:0] size_mask;
    logic       req_legal;
    logic       tmo_hit;
    logic       retry_exhausted;

    // Alignment only ever concerns the low byte of the address (sizes up to 128 bytes).
    assign size_mask       = (8'd1 << cpu_sel_i) - 8'd1;
    assign req_legal       = (cpu_sel_i <= 3'(MAX_SIZE)) && ((cpu_addr_i[7:0] & size_mask) == 8'd0);
    assign tmo_hit         = TMO_EN && (tmo_cnt == TMO_LAST);
    assign retry_exhausted = (retry_cnt == RETRY_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_ce_i) begin
                    state_d = req_legal ? S_REQ : S_ERR;
                end
            end
            S_REQ: begin
                if (!cpu_ce_i) begin
                    state_d = S_IDLE;
                end else if (M_HGRANT && M_HREADY) begin
                    state_d = S_ADDR;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_ADDR: begin
                if (M_HREADY) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // An abandoned request still finishes its bus transfer, then reports nothing.
                if (M_HREADY) begin
                    if (!cpu_ce_i) begin
                        state_d = S_IDLE;
                    end else if (M_HRESP == HRESP_OKAY) begin
                        state_d = S_DONE;
                    end else if (M_HRESP == HRESP_ERROR) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = retry_exhausted ? S_ERR : S_REQ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            lat_sel   <= '0;
            tmo_cnt   <= '0;
            retry_cnt <= '0;
            rdata_q   <= '0;
        end else begin
            if (state_q == S_IDLE && cpu_ce_i) begin
                lat_addr  <= cpu_addr_i;
                lat_we    <= cpu_we_i;
                lat_wdata <= cpu_writedata_i;
                lat_sel   <= cpu_sel_i;
            end

            if (TMO_EN && state_q == S_REQ && state_d == S_REQ) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            if (state_d == S_IDLE) begin
                retry_cnt <= '0;
            end else if (state_q == S_DATA && state_d == S_REQ) begin
                retry_cnt <= retry_cnt + 1'b1;
            end

            if (state_q == S_DATA && state_d == S_DONE && !lat_we) begin
                rdata_q <= M_HRDATA;
            end else begin
                rdata_q <= '0;
            end
        end
    end

    always_comb begin
        M_HBUSREQ = 1'b0;
        M_HTRANS  = HTRANS_IDLE;
        M_HADDR   = '0;
        M_HSIZE   = '0;
        M_HWRITE  = 1'b0;
        M_HBURST  = 3'b000;
        M_HWDATA  = '0;
        cpu_err_o = 1'b0;
        stallreq  = cpu_ce_i && (state_q != S_DONE) && (state_q != S_ERR);
        case (state_q)
            S_REQ: begin
                M_HBUSREQ = 1'b1;
            end
            S_ADDR: begin
                M_HBUSREQ = 1'b1;
                M_HTRANS  = HTRANS_NONSEQ;
                M_HADDR   = lat_addr;
                M_HSIZE   = lat_sel;
                M_HWRITE  = lat_we;
            end
            S_DATA: begin
                if (lat_we) begin
                    M_HWDATA = lat_wdata;
                end
            end
            S_ERR: begin
                cpu_err_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign cpu_readdata_o = rdata_q;

endmodule

// File: tb/tb_cpu_ahb_master.sv
// Directed bench for cpu_ahb_master: table of single transfers against a scripted
// slave, plus hand-written reset, abandon and timeout-adjacent sequences.
module tb_cpu_ahb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr_i;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_writedata_i;
    logic [2:0]  cpu_sel_i;
    logic [31:0] cpu_readdata_o;
    logic        cpu_err_o;
    logic        stallreq;
    logic        M_HGRANT;
    logic        M_HREADY;
    logic [1:0]  M_HRESP;
    logic [31:0] M_HRDATA;
    logic        M_HBUSREQ;
    logic [31:0] M_HADDR;
    logic [1:0]  M_HTRANS;
    logic [2:0]  M_HSIZE;
    logic [2:0]  M_HBURST;
    logic        M_HWRITE;
    logic [31:0] M_HWDATA;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_ahb_master #(
        .ADDR_W(32),
        .DATA_W(32),
        .GRANT_TIMEOUT(8),
        .RETRY_MAX(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_addr_i(cpu_addr_i),
        .cpu_ce_i(cpu_ce_i),
        .cpu_we_i(cpu_we_i),
        .cpu_writedata_i(cpu_writedata_i),
        .cpu_sel_i(cpu_sel_i),
        .cpu_readdata_o(cpu_readdata_o),
        .cpu_err_o(cpu_err_o),
        .stallreq(stallreq),
        .M_HGRANT(M_HGRANT),
        .M_HREADY(M_HREADY),
        .M_HRESP(M_HRESP),
        .M_HRDATA(M_HRDATA),
        .M_HBUSREQ(M_HBUSREQ),
        .M_HADDR(M_HADDR),
        .M_HTRANS(M_HTRANS),
        .M_HSIZE(M_HSIZE),
        .M_HBURST(M_HBURST),
        .M_HWRITE(M_HWRITE),
        .M_HWDATA(M_HWDATA)
    );

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  sel;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        int          nretry;
        logic [1:0]  resp;
        logic        grant;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_stall;
        int          exp_ns;
        int          exp_breq;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one request; the slave answers each data phase: RETRY (two-cycle) for the
    // first nretry phases, then `waits` wait states followed by resp.
    task automatic xfer(input vec_t v, output logic o_err, output logic [31:0] o_rd,
                        output int o_stall, output int o_ns, output int o_breq);
        bit fin = 0;
        int dw = -1;
        int phase = 0;
        o_err = 1'b0; o_rd = '0; o_stall = 0; o_ns = 0; o_breq = 0;
        @(negedge clk);
        cpu_addr_i = v.addr; cpu_sel_i = v.sel; cpu_we_i = v.we;
        cpu_writedata_i = v.wdata; cpu_ce_i = 1'b1;
        M_HGRANT = v.grant; M_HREADY = 1'b1; M_HRESP = 2'b00; M_HRDATA = v.rdata;
        for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
            #1;
            if (!stallreq) begin
                fin = 1;
                o_err = cpu_err_o;
                o_rd = cpu_readdata_o;
            end else begin
                o_stall++;
                if (M_HBUSREQ) o_breq++;
                if (M_HTRANS == 2'b10) begin
                    o_ns++;
                    check("haddr", M_HADDR, v.addr);
                    check("hsize", M_HSIZE, v.sel);
                    check("hwrite", M_HWRITE, v.we);
                    check("hburst", M_HBURST, 3'b000);
                    M_HREADY = 1'b1; M_HRESP = 2'b00;
                    dw = 0;
                end else if (dw >= 0) begin
                    check("hwdata", M_HWDATA, v.we ? v.wdata : 32'h0);
                    if (phase < v.nretry) begin
                        M_HRESP = 2'b10;
                        M_HREADY = (dw == 1);
                        if (dw == 1) begin phase++; dw = -1; end else dw++;
                    end else begin
                        M_HREADY = (dw == v.waits);
                        M_HRESP = (dw == v.waits) ? v.resp : 2'b00;
                        if (dw == v.waits) dw = -1; else dw++;
                    end
                end else begin
                    M_HREADY = 1'b1; M_HRESP = 2'b00;
                end
                @(negedge clk);
            end
        end
        check("xfer_complete", fin, 1);
        cpu_ce_i = 1'b0; M_HREADY = 1'b1; M_HRESP = 2'b00; M_HGRANT = 1'b1;
        @(negedge clk);
        #1;
        check("err_pulse_end", cpu_err_o, 1'b0);
        check("rdata_after", cpu_readdata_o, 32'h0);
    endtask

    task automatic wait_nonseq();
        for (int i = 0; i < 10 && M_HTRANS != 2'b10; i++) begin
            @(negedge clk);
            #1;
        end
        check("saw_nonseq", M_HTRANS, 2'b10);
    endtask

    logic        r_err;
    logic [31:0] r_rd;
    int          r_stall, r_ns, r_breq;

    initial begin
        // addr, sel, we, wdata, rdata, waits, nretry, resp, grant | err, rdata, stall, nonseq, busreq
        vecs[0]  = '{32'h1000, 3'd2, 1'b0, 32'h0,        32'hDEADBEEF, 0, 0, 2'b00, 1'b1, 1'b0, 32'hDEADBEEF, 4, 1, 2};
        vecs[1]  = '{32'h2004, 3'd2, 1'b1, 32'h12345678, 32'h0,        3, 0, 2'b00, 1'b1, 1'b0, 32'h0,        7, 1, 2};
        vecs[2]  = '{32'h3002, 3'd2, 1'b0, 32'h0,        32'h0,        0, 0, 2'b00, 1'b1, 1'b1, 32'h0,        1, 0, 0};
        vecs[3]  = '{32'h3002, 3'd1, 1'b0, 32'h0,        32'h0000ABCD, 1, 0, 2'b00, 1'b1, 1'b0, 32'h0000ABCD, 5, 1, 2};
        vecs[4]  = '{32'h4001, 3'd0, 1'b1, 32'h000000EE, 32'h0,        0, 0, 2'b00, 1'b1, 1'b0, 32'h0,        4, 1, 2};
        vecs[5]  = '{32'h4001, 3'd1, 1'b0, 32'h0,        32'h0,        0, 0, 2'b00, 1'b1, 1'b1, 32'h0,        1, 0, 0};
        vecs[6]  = '{32'h5000, 3'd3, 1'b0, 32'h0,        32'h0,        0, 0, 2'b00, 1'b1, 1'b1, 32'h0,        1, 0, 0};
        vecs[7]  = '{32'h6006, 3'd2, 1'b1, 32'h0BADF00D, 32'h0,        0, 0, 2'b00, 1'b1, 1'b1, 32'h0,        1, 0, 0};
        vecs[8]  = '{32'h7FFC, 3'd2, 1'b0, 32'h0,        32'hA5A55A5A, 2, 0, 2'b00, 1'b1, 1'b0, 32'hA5A55A5A, 6, 1, 2};
        vecs[9]  = '{32'h9000, 3'd2, 1'b0, 32'h0,        32'h11223344, 0, 1, 2'b00, 1'b1, 1'b0, 32'h11223344, 8, 2, 4};
        vecs[10] = '{32'h9000, 3'd2, 1'b0, 32'h0,        32'h11223344, 0, 2, 2'b00, 1'b1, 1'b1, 32'h0,        9, 2, 4};
        vecs[11] = '{32'hA000, 3'd2, 1'b0, 32'h0,        32'h99999999, 1, 0, 2'b01, 1'b1, 1'b1, 32'h0,        5, 1, 2};
        vecs[12] = '{32'hB000, 3'd2, 1'b0, 32'h0,        32'h0,        0, 0, 2'b00, 1'b0, 1'b1, 32'h0,        9, 0, 8};
        vecs[13] = '{32'hC000, 3'd2, 1'b1, 32'h87654321, 32'h0,        0, 1, 2'b00, 1'b1, 1'b0, 32'h0,        8, 2, 4};

        rst = 1'b1; cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0;
        cpu_writedata_i = '0; M_HGRANT = 1'b1; M_HREADY = 1'b1; M_HRESP = 2'b00; M_HRDATA = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busreq", M_HBUSREQ, 1'b0);
        check("rst_htrans", M_HTRANS, 2'b00);
        check("rst_err", cpu_err_o, 1'b0);
        check("rst_rdata", cpu_readdata_o, 32'h0);
        check("rst_stall", stallreq, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            xfer(vecs[i], r_err, r_rd, r_stall, r_ns, r_breq);
            check($sformatf("v%0d_err", i), r_err, vecs[i].exp_err);
            check($sformatf("v%0d_rdata", i), r_rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_stall", i), r_stall, vecs[i].exp_stall);
            check($sformatf("v%0d_nonseq", i), r_ns, vecs[i].exp_ns);
            check($sformatf("v%0d_busreq", i), r_breq, vecs[i].exp_breq);
        end

        // Request withdrawn while waiting for grant: nothing issued, no pulse.
        @(negedge clk);
        cpu_addr_i = 32'hE000; cpu_sel_i = 3'd2; cpu_we_i = 1'b0; cpu_ce_i = 1'b1; M_HGRANT = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("drop_req_busreq", M_HBUSREQ, 1'b1);
        cpu_ce_i = 1'b0;
        #1;
        check("drop_req_stall", stallreq, 1'b0);
        @(negedge clk);
        #1;
        check("drop_req_idle", M_HBUSREQ, 1'b0);
        check("drop_req_err", cpu_err_o, 1'b0);
        check("drop_req_trans", M_HTRANS, 2'b00);
        M_HGRANT = 1'b1;
        xfer(vecs[0], r_err, r_rd, r_stall, r_ns, r_breq);
        check("after_drop_rdata", r_rd, 32'hDEADBEEF);
        check("after_drop_stall", r_stall, 4);

        // Request withdrawn during a data wait: bus completes, CPU sees nothing.
        @(negedge clk);
        cpu_addr_i = 32'hF000; cpu_sel_i = 3'd2; cpu_we_i = 1'b0; cpu_ce_i = 1'b1; M_HRDATA = 32'h55AA55AA;
        #1;
        wait_nonseq();
        @(negedge clk);
        #1;
        M_HREADY = 1'b0; cpu_ce_i = 1'b0;
        #1;
        check("drop_data_stall", stallreq, 1'b0);
        @(negedge clk);
        #1;
        M_HREADY = 1'b1;
        @(negedge clk);
        #1;
        check("drop_data_err", cpu_err_o, 1'b0);
        check("drop_data_rdata", cpu_readdata_o, 32'h0);
        check("drop_data_busreq", M_HBUSREQ, 1'b0);
        xfer(vecs[3], r_err, r_rd, r_stall, r_ns, r_breq);
        check("after_data_drop_rdata", r_rd, 32'h0000ABCD);

        // Asynchronous reset in the middle of a write data wait.
        @(negedge clk);
        cpu_addr_i = 32'hD000; cpu_sel_i = 3'd2; cpu_we_i = 1'b1; cpu_writedata_i = 32'hCAFEF00D; cpu_ce_i = 1'b1;
        #1;
        wait_nonseq();
        @(negedge clk);
        #1;
        M_HREADY = 1'b0;
        check("pre_rst_hwdata", M_HWDATA, 32'hCAFEF00D);
        #1;
        rst = 1'b1; cpu_ce_i = 1'b0;
        #1;
        check("arst_hwdata", M_HWDATA, 32'h0);
        check("arst_busreq", M_HBUSREQ, 1'b0);
        check("arst_htrans", M_HTRANS, 2'b00);
        check("arst_haddr", M_HADDR, 32'h0);
        check("arst_hwrite", M_HWRITE, 1'b0);
        check("arst_hsize", M_HSIZE, 3'b000);
        check("arst_err", cpu_err_o, 1'b0);
        check("arst_stall", stallreq, 1'b0);
        @(negedge clk);
        rst = 1'b0; M_HREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_busreq", M_HBUSREQ, 1'b0);
            check("post_rst_err", cpu_err_o, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_ahb_master.md
Name: cpu_ahb_master

Overview:
Parametrised CPU-side AHB-Lite master, the next generation of the single-transfer CPU bus interface. It converts one CPU load/store request into one arbitrated AHB SINGLE transfer with a proper address phase and data phase. It honours HREADY wait states and decodes HRESP (ERROR, RETRY, SPLIT). It also adds a grant timeout, a retry limit, alignment/size checking and an error flag back to the CPU pipeline, and it drives the pipeline stall.

Parameters:
ADDR_W, 32, address width of CPU and AHB address buses
DATA_W, 32, data width (32 or 64); max legal HSIZE = log2(DATA_W/8)
GRANT_TIMEOUT, 255, cycles waiting for grant before error; 0 disables timeout
RETRY_MAX, 3, RETRY/SPLIT responses tolerated per request before error

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cpu_addr_i  in  ADDR_W  CPU byte address
cpu_ce_i  in  1  CPU access request, held until completion pulse
cpu_we_i  in  1  1 = write, 0 = read
cpu_writedata_i  in  DATA_W  write data
cpu_sel_i  in  3  transfer size, HSIZE encoding
cpu_readdata_o  out  DATA_W  registered read data, valid in completion cycle
cpu_err_o  out  1  one-cycle error pulse in completion cycle
stallreq  out  1  pipeline stall request to ctrl
M_HGRANT  in  1  arbiter grant
M_HREADY  in  1  transfer ready
M_HRESP  in  2  response: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT
M_HRDATA  in  DATA_W  read data
M_HBUSREQ  out  1  bus request
M_HADDR  out  ADDR_W  address
M_HTRANS  out  2  00 IDLE / 10 NONSEQ only
M_HSIZE  out  3  transfer size
M_HBURST  out  3  always 000 (SINGLE)
M_HWRITE  out  1  direction
M_HWDATA  out  DATA_W  write data, driven only in write data phase, else 0

Behaviour:
- Reset: state IDLE; all outputs 0; retry and timeout counters 0. Reset mid-transfer aborts immediately; no completion pulse.
- stallreq is combinational: cpu_ce_i && state not in {DONE, ERR}. It is 0 whenever cpu_ce_i = 0.
- Request latch: on leaving IDLE, capture addr, we, wdata and sel into internal registers. Bus outputs are driven from the latch only.
- IDLE: if cpu_ce_i and the request is illegal -> ERR with no bus activity.
  - Illegal means sel > log2(DATA_W/8), or addr not aligned to 2^sel bytes.
  - Otherwise, if cpu_ce_i -> REQ.
- REQ: M_HBUSREQ = 1, HTRANS = IDLE.
  - M_HGRANT && M_HREADY at the edge -> ADDR.
  - cpu_ce_i drops -> IDLE, nothing issued.
  - Timeout counter increments each REQ cycle. When it reaches GRANT_TIMEOUT (nonzero) -> ERR; HBUSREQ drops that edge.
- ADDR: HTRANS = NONSEQ; HADDR/HWRITE/HSIZE from the latch; HBURST = 000; HBUSREQ = 1. M_HREADY = 1 -> DATA; otherwise hold.
- DATA: HTRANS = IDLE, HBUSREQ = 0. HWDATA = latched wdata if write, else 0.
  - HREADY=0: hold; covers wait states and the first cycle of a two-cycle response.
  - HREADY=1 and OKAY: read stores HRDATA into cpu_readdata_o -> DONE.
  - HREADY=1 and ERROR: -> ERR.
  - HREADY=1 and RETRY/SPLIT: retry_cnt++ and go back to REQ with the same latched request; if retry_cnt would exceed RETRY_MAX -> ERR.
  - A started transfer always completes on the bus, even if cpu_ce_i drops. In that case completion goes -> IDLE, no pulse, and readdata is not updated.
- DONE: one cycle; stallreq = 0, cpu_err_o = 0; -> IDLE. Writes leave cpu_readdata_o = 0.
- ERR: one cycle; cpu_err_o = 1, stallreq = 0, cpu_readdata_o = 0; -> IDLE.
- Counters clear on entry to IDLE.
- Back-to-back: a new request is seen in IDLE the cycle after DONE/ERR, giving minimum 4 cycles per access (IDLE, REQ, ADDR, DATA) plus the completion cycle.
- Latency with immediate grant and zero wait states: stallreq high for 4 cycles, then DONE.

Test Plan:
- Read 0x1000, sel=2, grant immediate, HRDATA=0xDEADBEEF, HREADY=1 -> NONSEQ at 0x1000 one cycle; DONE with readdata=0xDEADBEEF; stall 4 cycles then 0.
- Write 0x2004, data 0x12345678, 3 wait states -> HWDATA=0x12345678 stable across 4 data cycles; one DONE pulse, err=0.
- Read 0x3002 sel=2 (misaligned) -> no HBUSREQ, no NONSEQ; cpu_err_o=1 one cycle after ce.
- Grant withheld, GRANT_TIMEOUT=8 -> HBUSREQ high 8 cycles, then ERR pulse; HTRANS never NONSEQ.
- Two-cycle RETRY response (HREADY 0 then 1), RETRY_MAX=1 -> re-request and re-issue once. A second RETRY -> ERR; an OKAY instead -> DONE.
- rst asserted during DATA wait -> all outputs 0 asynchronously; after release with ce=0, HBUSREQ stays 0.
